dsd7_uart: RTL and testbench
============================

// Module: dsd7_uart
// PURPOSE
//  Serial UART peripheral on the IOBridge iob1 master-side bus, alongside keyboard/LEDs/sseg.
//  Drives board UartTx and samples UartRx; 16x-oversampled 8N1, TX and RX FIFOs, level IRQ to DSD7_mpu.
//  dat_o is zero when not selected, so it can be OR'd into the iob1 m_dat_i / m_ack_i reductions.
// PARAMETERS
//  pIOAddress   32'hFFDC0A00  base address; block decodes adr_i[31:4]==pIOAddress[31:4]
//  pDefDiv      16'd13        reset baud divisor (25MHz/(16*115200) - 1)
//  pFifoAw      4             FIFO address width; depth = 2**pFifoAw entries per direction
// PORTS
//  clk_i   in   1   system clock (sys_clk)
//  rst_ni  in   1   reset, asynchronous, active-low
//  cyc_i   in   1   bus cycle
//  stb_i   in   1   bus strobe
//  ack_o   out  1   bus acknowledge
//  we_i    in   1   write enable
//  adr_i   in   32  byte address; register select = adr_i[3:2]
//  dat_i   in   32  write data
//  dat_o   out  32  read data; 0 when not selected or not acking
//  rxd_i   in   1   serial in (UartRx), async
//  txd_o   out  1   serial out (UartTx), idle high
//  irq_o   out  1   level interrupt
// BEHAVIOUR
//  Reset: ack_o=0, dat_o=0, txd_o=1, irq_o=0, both FIFOs empty, divisor=pDefDiv, ctrl=0, sticky flags=0.
//  Bus: cs = cyc_i&stb_i&addr match. ack_o registered: rises 1 clk after cs, falls the clk after cs drops.
//   Exactly one side effect per access (taken on the cycle ack_o rises).
//  Regs: 0 DATA  W: push dat_i[7:0] to TX FIFO (dropped if full). R: {24'h0, rx head}, pops RX; empty -> 0, no pop.
//        1 STAT  R: [0]rx_nempty [1]tx_nfull [2]tx_idle(FIFO empty & shifter IDLE) [3]overrun [4]framing
//                   [12:8]rx_count. W: 1 to [3]/[4] clears that flag.
//        2 CTRL  [0]rxie [1]txie (R/W). 3 DIV [15:0] baud divisor (R/W); a write restarts the tick counter.
//  Tick: 16-bit down-counter reloads with DIV; tick pulses 1 clk on reaching 0 (period DIV+1 clks).
//  RX: rxd_i via 2-flop sync. States IDLE->START->DATA->STOP.
//   IDLE: falling edge -> START, ticks count cleared.
//   START: at 8th tick recheck low; high = glitch -> IDLE.
//   DATA: sample every 16 ticks, LSB first, 8 bits.
//   STOP: sample at 16th tick. Stop=1 -> push byte; FIFO full -> drop, set overrun. Stop=0 -> drop, set framing.
//   Then IDLE. No RX back-to-back gap required.
//  TX: IDLE->START->DATA->STOP, each bit 16 ticks, LSB first.
//   IDLE pops FIFO when non-empty on next tick; STOP returns to IDLE or directly reloads if FIFO non-empty.
//  Simultaneous: RX push + CPU pop same clk both occur, count unchanged; full+pop+push legal.
//   Flag set and clear same clk: set wins.
//  irq_o registered = (rxie&rx_nempty)|(txie&tx_idle)|overrun|framing.
//  DIV write mid-frame: takes effect at next reload; frame may corrupt, no lockup.
//  Reset mid-frame: txd_o to 1 asynchronously, all state aborted.
//  Widths: rx_count is pFifoAw+1 bits, zero-extended into [12:8]; ptrs wrap mod 2**pFifoAw.
// STRUCTURE
//  dsd7_uart_defs.vh: register offsets, STAT bit indices, RX/TX state encodings, oversample = 16.
//  Sub-module dsd7_uart_fifo (sync FIFO, push/pop/full/empty/count) instantiated twice (TX, RX).
//  Baud tick, RX FSM, TX FSM, bus decode in this module.
// TESTING
//  1 Reset, DIV=0 (tick every clk): write DATA=0x55 -> txd_o start bit then 1,0,1,0,1,0,1,0, stop;
//    each bit 16 clks.
//  2 Loop txd_o->rxd_i, write 0xA3,0x00,0xFF -> STAT[0]=1, rx_count=3; reads return 0xA3,0x00,0xFF, then 0.
//  3 Drive 17 frames with no reads (depth 16) -> STAT[3]=1, rx_count=16; 17th byte lost.
//    Write STAT=0x08 -> [3] clears.
//  4 Frame with stop bit 0 -> no push, STAT[4]=1, irq_o=1 with rxie=0.
//  5 1-tick-wide low pulse on rxd_i in IDLE -> no byte, no flags.
//  6 CTRL=2, TX idle -> irq_o=1. Write DATA -> irq_o=0 until stop bit done, then 1.
//    Deassert rst_ni mid-frame -> txd_o=1 immediately.

Source files
------------

// File: rtl/dsd7_uart_pkg.sv
// dsd7_uart_pkg: register map, status bit positions, oversampling constants and serial FSM states
package dsd7_uart_pkg;
  localparam logic [1:0] R_DATA = 2'd0;
  localparam logic [1:0] R_STAT = 2'd1;
  localparam logic [1:0] R_CTRL = 2'd2;
  localparam logic [1:0] R_DIV  = 2'd3;
  localparam int S_RXNE   = 0;
  localparam int S_TXNF   = 1;
  localparam int S_TXIDLE = 2;
  localparam int S_OVR    = 3;
  localparam int S_FRM    = 4;
  localparam int S_CNT    = 8;
  localparam int OVS = 16;
  localparam logic [3:0] OVS_LAST = 4'(OVS - 1);
  localparam logic [3:0] OVS_MID  = 4'(OVS / 2 - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_t;
endpackage

// File: rtl/dsd7_uart_if.sv
// dsd7_uart_if: iob1 slave bus bundle between the bridge and the UART
interface dsd7_uart_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic        ack_o;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input ack_o, dat_o);
  modport slave  (input cyc_i, stb_i, we_i, adr_i, dat_i, output ack_o, dat_o);
endinterface

// File: rtl/dsd7_uart_fifo.sv
// dsd7_uart_fifo: byte-wide synchronous FIFO; a push while full is accepted only alongside a pop
module dsd7_uart_fifo #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count[AW];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + (AW)'(1);
      if (do_pop) rp <= rp + (AW)'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/dsd7_uart.sv
// dsd7_uart: 16x-oversampled 8N1 UART on iob1 with TX/RX FIFOs, baud divisor and level IRQ
module dsd7_uart
  import dsd7_uart_pkg::*;
#(
  parameter logic [31:0] pIOAddress = 32'hFFDC0A00,
  parameter logic [15:0] pDefDiv    = 16'd13,
  parameter int          pFifoAw    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  dsd7_uart_if.slave  b,
  input  logic        rxd_i,
  output logic        txd_o,
  output logic        irq_o
);
  logic             cs, act, rd, wr, ack, tick;
  logic [1:0]       rs;
  logic [31:0]      rdat, rval, stat;
  logic [1:0]       ctrl;
  logic [15:0]      div, cnt;
  logic             ovr, frm, irq, ovr_set, frm_set;
  logic             rx_m, rx_s, rx_p, rx_fall;
  uart_st_t         rx_st, rx_nst, tx_st, tx_nst;
  logic [3:0]       rx_tc, rx_ntc, tx_tc, tx_ntc;
  logic [2:0]       rx_bc, rx_nbc, tx_bc, tx_nbc;
  logic [7:0]       rx_sh, rx_nsh, tx_sh, tx_nsh;
  logic             rx_done, rx_pop, rx_full, rx_empty;
  logic             tx_push, tx_pop, tx_full, tx_empty, tx_idle, txd, txd_n;
  logic [7:0]       rx_dout, tx_dout;
  logic [pFifoAw:0] rx_cnt, tx_cnt;
  logic             unused_ok;
  assign cs        = b.cyc_i & b.stb_i & (b.adr_i[31:4] == pIOAddress[31:4]);
  assign act       = cs & ~ack;
  assign rs        = b.adr_i[3:2];
  assign wr        = act & b.we_i;
  assign rd        = act & ~b.we_i;
  assign b.ack_o   = ack;
  assign b.dat_o   = (ack & cs) ? rdat : 32'd0;
  assign txd_o     = txd;
  assign irq_o     = irq;
  assign tick      = cnt == 16'd0;
  assign rx_fall   = rx_p & ~rx_s;
  assign rx_pop    = rd & (rs == R_DATA) & ~rx_empty;
  assign tx_push   = wr & (rs == R_DATA);
  assign tx_idle   = tx_empty & (tx_st == ST_IDLE);
  assign ovr_set   = rx_done & rx_full & ~rx_pop;
  assign unused_ok = ^{b.dat_i[31:16], b.adr_i[1:0], tx_cnt};
  dsd7_uart_fifo #(.AW(pFifoAw)) u_rxf (
    .clk(clk_i), .rst_n(rst_ni), .push(rx_done), .pop(rx_pop), .din(rx_sh),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );
  dsd7_uart_fifo #(.AW(pFifoAw)) u_txf (
    .clk(clk_i), .rst_n(rst_ni), .push(tx_push), .pop(tx_pop), .din(b.dat_i[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );
  always_comb begin
    stat           = 32'(rx_cnt) << S_CNT;
    stat[S_RXNE]   = ~rx_empty;
    stat[S_TXNF]   = ~tx_full;
    stat[S_TXIDLE] = tx_idle;
    stat[S_OVR]    = ovr;
    stat[S_FRM]    = frm;
    rval = (rs == R_DATA) ? (rx_empty ? 32'd0 : {24'd0, rx_dout}) :
           (rs == R_STAT) ? stat :
           (rs == R_CTRL) ? {30'd0, ctrl} : {16'd0, div};
  end
  // Receiver: start confirmed mid-bit, then every bit sampled one full bit-time later
  always_comb begin
    rx_nst  = rx_st;
    rx_ntc  = rx_tc;
    rx_nbc  = rx_bc;
    rx_nsh  = rx_sh;
    rx_done = 1'b0;
    frm_set = 1'b0;
    case (rx_st)
      ST_IDLE: if (rx_fall) begin
        rx_nst = ST_START;
        rx_ntc = '0;
      end
      ST_START: if (tick) begin
        rx_ntc = rx_tc + 4'd1;
        if (rx_tc == OVS_MID) begin
          rx_nst = rx_s ? ST_IDLE : ST_DATA;
          rx_ntc = '0;
          rx_nbc = '0;
        end
      end
      ST_DATA: if (tick) begin
        rx_ntc = rx_tc + 4'd1;
        if (rx_tc == OVS_LAST) begin
          rx_nsh = {rx_s, rx_sh[7:1]};
          rx_nbc = rx_bc + 3'd1;
          if (rx_bc == 3'd7) rx_nst = ST_STOP;
        end
      end
      ST_STOP: if (tick) begin
        rx_ntc = rx_tc + 4'd1;
        if (rx_tc == OVS_LAST) begin
          rx_nst  = ST_IDLE;
          rx_done = rx_s;
          frm_set = ~rx_s;
        end
      end
    endcase
  end
  // Transmitter: STOP chains straight into the next START when more bytes are queued
  always_comb begin
    tx_nst = tx_st;
    tx_ntc = tx_tc;
    tx_nbc = tx_bc;
    tx_nsh = tx_sh;
    tx_pop = 1'b0;
    case (tx_st)
      ST_IDLE: if (tick & ~tx_empty) begin
        tx_pop = 1'b1;
        tx_nsh = tx_dout;
        tx_nst = ST_START;
        tx_ntc = '0;
      end
      ST_START: if (tick) begin
        tx_ntc = tx_tc + 4'd1;
        if (tx_tc == OVS_LAST) begin
          tx_nst = ST_DATA;
          tx_nbc = '0;
        end
      end
      ST_DATA: if (tick) begin
        tx_ntc = tx_tc + 4'd1;
        if (tx_tc == OVS_LAST) begin
          tx_nsh = {1'b1, tx_sh[7:1]};
          tx_nbc = tx_bc + 3'd1;
          if (tx_bc == 3'd7) tx_nst = ST_STOP;
        end
      end
      ST_STOP: if (tick) begin
        tx_ntc = tx_tc + 4'd1;
        if (tx_tc == OVS_LAST) begin
          tx_pop = ~tx_empty;
          tx_nsh = tx_empty ? tx_sh : tx_dout;
          tx_nst = tx_empty ? ST_IDLE : ST_START;
        end
      end
    endcase
    txd_n = (tx_nst == ST_START) ? 1'b0 : (tx_nst == ST_DATA) ? tx_nsh[0] : 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ack   <= 1'b0;
      rdat  <= '0;
      ctrl  <= '0;
      div   <= pDefDiv;
      cnt   <= pDefDiv;
      ovr   <= 1'b0;
      frm   <= 1'b0;
      irq   <= 1'b0;
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      rx_p  <= 1'b1;
      rx_st <= ST_IDLE;
      rx_tc <= '0;
      rx_bc <= '0;
      rx_sh <= '0;
      tx_st <= ST_IDLE;
      tx_tc <= '0;
      tx_bc <= '0;
      tx_sh <= '0;
      txd   <= 1'b1;
    end else begin
      ack <= cs;
      if (rd) rdat <= rval;
      if (wr & (rs == R_CTRL)) ctrl <= b.dat_i[1:0];
      if (wr & (rs == R_DIV)) div <= b.dat_i[15:0];
      cnt   <= (wr & (rs == R_DIV)) ? b.dat_i[15:0] : tick ? div : cnt - 16'd1;
      ovr   <= ovr_set | (ovr & ~(wr & (rs == R_STAT) & b.dat_i[S_OVR]));
      frm   <= frm_set | (frm & ~(wr & (rs == R_STAT) & b.dat_i[S_FRM]));
      irq   <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_idle) | ovr | frm;
      rx_m  <= rxd_i;
      rx_s  <= rx_m;
      rx_p  <= rx_s;
      rx_st <= rx_nst;
      rx_tc <= rx_ntc;
      rx_bc <= rx_nbc;
      rx_sh <= rx_nsh;
      tx_st <= tx_nst;
      tx_tc <= tx_ntc;
      tx_bc <= tx_nbc;
      tx_sh <= tx_nsh;
      txd   <= txd_n;
    end
endmodule

// File: tb/tb_dsd7_uart.sv
// tb_dsd7_uart: directed scoreboard bench; bus reads queue expectations, a negedge monitor checks them
module tb_dsd7_uart;
  localparam logic [31:0] BASE = 32'hFFDC0A00;
  logic clk = 1'b0, rst_n = 1'b0, rxd_drv = 1'b1, loop = 1'b0;
  logic txd, irq, rxd;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  string nm_q[$];
  logic [31:0] m_e;
  string m_n;
  dsd7_uart_if b();
  dsd7_uart dut (.clk_i(clk), .rst_ni(rst_n), .b(b), .rxd_i(rxd), .txd_o(txd), .irq_o(irq));
  assign rxd = loop ? txd : rxd_drv;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (b.ack_o && b.cyc_i && !b.we_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got 0x%0h expected no read", b.dat_o);
      end else begin
        m_e = exp_q.pop_front();
        m_n = nm_q.pop_front();
        if (b.dat_o !== m_e) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", m_n, b.dat_o, m_e);
        end
      end
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic bus(input logic we, input logic [1:0] r, input logic [31:0] d);
    logic got = 1'b0;
    @(posedge clk); #1;
    b.cyc_i = 1'b1; b.stb_i = 1'b1; b.we_i = we; b.adr_i = BASE | {28'd0, r, 2'b00}; b.dat_i = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #2;
      got = b.ack_o;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL bus_ack: got no ack expected ack (reg %0d)", r);
      if (!we) begin
        void'(exp_q.pop_back());
        void'(nm_q.pop_back());
      end
    end
    @(negedge clk); #1;
    b.cyc_i = 1'b0; b.stb_i = 1'b0; b.we_i = 1'b0;
  endtask
  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    bus(1'b1, r, d);
  endtask
  task automatic rd(input logic [1:0] r, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    bus(1'b0, r, 32'd0);
  endtask
  task automatic reset_dut();
    loop = 1'b0;
    rxd_drv = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk); #1 rxd_drv = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd_drv = d[i];
      repeat (16) @(posedge clk);
    end
    #1 rxd_drv = stop;
    repeat (16) @(posedge clk);
    #1 rxd_drv = 1'b1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [9:0] fr;
    int n;
    logic found;
    b.cyc_i = 1'b0; b.stb_i = 1'b0; b.we_i = 1'b0; b.adr_i = '0; b.dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, b.ack_o}, 32'd0);
    chk("rst_dat", b.dat_o, 32'd0);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset_dut();
    rd(2'd1, 32'h0000_0006, "rst_stat");
    rd(2'd2, 32'h0, "rst_ctrl");
    rd(2'd3, 32'h0000_000D, "rst_div");
    rd(2'd0, 32'h0, "rst_data_empty");
    @(posedge clk); #1;
    b.cyc_i = 1'b1; b.stb_i = 1'b1; b.adr_i = BASE + 32'h10;
    repeat (3) @(posedge clk);
    #2;
    chk("miss_ack", {31'd0, b.ack_o}, 32'd0);
    chk("miss_dat", b.dat_o, 32'd0);
    b.cyc_i = 1'b0; b.stb_i = 1'b0;
    wr(2'd3, 32'h1234);
    rd(2'd3, 32'h1234, "div_rw");
    wr(2'd2, 32'h3);
    rd(2'd2, 32'h3, "ctrl_rw");
    wr(2'd2, 32'h0);
    // test 1: 0x55 on the wire, 16 clocks per bit at DIV=0
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h55);
    fr = {1'b1, 8'h55, 1'b0};
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = ~txd;
    end
    chk("tx_start_seen", {31'd0, found}, 32'd1);
    if (found)
      for (n = 0; n < 160; n++) begin
        if (n > 0) @(negedge clk);
        if (n % 16 == 0 || n % 16 == 15) chk($sformatf("tx_bit%0d_off%0d", n / 16, n % 16), {31'd0, txd}, {31'd0, fr[n / 16]});
      end
    // test 2: loopback of three bytes
    reset_dut();
    loop = 1'b1;
    wr(2'd3, 32'h0);
    wr(2'd0, 32'hA3);
    wr(2'd0, 32'h00);
    wr(2'd0, 32'hFF);
    repeat (700) @(posedge clk);
    rd(2'd1, 32'h0000_0307, "loop_stat");
    rd(2'd0, 32'hA3, "loop_rx0");
    rd(2'd0, 32'h00, "loop_rx1");
    rd(2'd0, 32'hFF, "loop_rx2");
    rd(2'd0, 32'h00, "loop_rx_empty");
    rd(2'd1, 32'h0000_0006, "loop_stat_after");
    // test 3: 17 frames into a 16-deep FIFO
    reset_dut();
    wr(2'd3, 32'h0);
    for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
    repeat (5) @(posedge clk);
    rd(2'd1, 32'h0000_100F, "ovr_stat");
    chk("ovr_irq", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'h08);
    rd(2'd1, 32'h0000_1007, "ovr_cleared");
    for (int i = 0; i < 16; i++) rd(2'd0, 32'(8'h10 + i), $sformatf("ovr_rx%0d", i));
    rd(2'd0, 32'h0, "ovr_rx_empty");
    rd(2'd1, 32'h0000_0006, "ovr_stat_after");
    // test 4: framing error
    reset_dut();
    wr(2'd3, 32'h0);
    send_frame(8'h5A, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("frm_irq", {31'd0, irq}, 32'd1);
    rd(2'd1, 32'h0000_0016, "frm_stat");
    wr(2'd1, 32'h10);
    rd(2'd1, 32'h0000_0006, "frm_cleared");
    // test 5: one-clock glitch must not start a frame
    reset_dut();
    wr(2'd3, 32'h0);
    @(posedge clk); #1 rxd_drv = 1'b0;
    @(posedge clk); #1 rxd_drv = 1'b1;
    repeat (300) @(posedge clk);
    rd(2'd1, 32'h0000_0006, "glitch_stat");
    rd(2'd0, 32'h0, "glitch_data");
    #1 chk("glitch_irq", {31'd0, irq}, 32'd0);
    // test 6: TX idle interrupt and asynchronous reset mid-frame
    reset_dut();
    wr(2'd3, 32'h0);
    wr(2'd2, 32'h2);
    repeat (2) @(posedge clk);
    #1 chk("txie_idle_irq", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h81);
    repeat (2) @(posedge clk);
    #1 chk("txie_busy_irq", {31'd0, irq}, 32'd0);
    n = 0;
    found = 1'b0;
    while (n < 400 && !found) begin
      @(negedge clk);
      n++;
      found = irq;
    end
    chk("txie_irq_returns", {31'd0, found}, 32'd1);
    chk("txie_irq_delay_in_range", {31'd0, n >= 150 && n <= 170}, 32'd1);
    chk("txie_txd_idle", {31'd0, txd}, 32'd1);
    wr(2'd0, 32'h00);
    repeat (40) @(posedge clk);
    #1 chk("midframe_txd_low", {31'd0, txd}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_txd", {31'd0, txd}, 32'd1);
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    rd(2'd1, 32'h0000_0006, "post_rst_stat");
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
